// File: rtl/regfile_pkg.sv
// Shared register-file constants and types, common to the write decoder,
// the read-port mux tree and the register bank.
package regfile_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 64;
   localparam int NUM_REGS   = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [REG_DATA_W-1:0] reg_data_t;

   // X31 reads as zero; writes to it are dropped.
   localparam reg_addr_t ZERO_REG = 5'd31;

endpackage

// File: rtl/decoder2_4.sv
// 2-to-4 one-hot decoder with enable.
module decoder2_4 (
   input  logic       en,
   input  logic [1:0] addr,
   output logic [3:0] onehot
);

   // Single bit set when enabled, all zero otherwise.
   always_comb begin
      onehot = '0;
      if (en) onehot[addr] = 1'b1;
   end

endmodule

// File: rtl/decoder3_8.sv
// 3-to-8 one-hot decoder with enable.
module decoder3_8 (
   input  logic       en,
   input  logic [2:0] addr,
   output logic [7:0] onehot
);

   // Single bit set when enabled, all zero otherwise.
   always_comb begin
      onehot = '0;
      if (en) onehot[addr] = 1'b1;
   end

endmodule

// File: rtl/decoder5_32.sv
// 5-to-32 one-hot decoder: the upper two address bits pick one of four
// 3-to-8 banks, mirroring the mux8_1/mux4_1 tree on the read side.
module decoder5_32 (
   input  logic        en,
   input  logic [4:0]  addr,
   output logic [31:0] onehot
);

   logic [3:0] bank_sel;

   decoder2_4 u_hi (
      .en     (en),
      .addr   (addr[4:3]),
      .onehot (bank_sel)
   );

   for (genvar g = 0; g < 4; g++) begin : g_lo
      decoder3_8 u_lo (
         .en     (bank_sel[g]),
         .addr   (addr[2:0]),
         .onehot (onehot[g*8 +: 8])
      );
   end

endmodule

// File: rtl/regfile_write_decoder.sv
// Register-file write stage: registers one write per cycle, drives a one-hot
// row enable plus data to the bank a cycle later, exposes the in-flight write
// for decode-stage bypass, and counts committed writes.
module regfile_write_decoder
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic [ADDR_WIDTH-1:0]      wr_addr,
   input  logic [DATA_WIDTH-1:0]      wr_data,
   input  logic [ADDR_WIDTH-1:0]      rd_addr_a,
   input  logic [ADDR_WIDTH-1:0]      rd_addr_b,
   output logic [(2**ADDR_WIDTH)-1:0] row_en,
   output logic [DATA_WIDTH-1:0]      row_data,
   output logic                       pend_valid,
   output logic [ADDR_WIDTH-1:0]      pend_addr,
   output logic                       fwd_a,
   output logic                       fwd_b,
   output logic [DATA_WIDTH-1:0]      fwd_data,
   output logic [15:0]                commit_cnt
);

   // Highest address is the hardwired-zero register.
   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = '1;
   localparam logic [15:0]           CNT_MAX   = 16'hFFFF;

   logic                  v_d, v_q;
   logic [ADDR_WIDTH-1:0] addr_d, addr_q;
   logic [DATA_WIDTH-1:0] data_d, data_q;
   logic [15:0]           cnt_d, cnt_q;

   // Qualify the request (drop zero-register writes); address/data only move
   // on a real write so the bank-facing bus never picks up idle-cycle junk.
   always_comb begin
      v_d    = wr_en && (wr_addr != ZERO_ADDR);
      addr_d = addr_q;
      data_d = data_q;
      cnt_d  = cnt_q;
      if (v_d) begin
         addr_d = wr_addr;
         data_d = wr_data;
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + 16'd1;
      end
   end

   // Stage register and commit counter, synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         v_q    <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         v_q    <= v_d;
         addr_q <= addr_d;
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

   if (ADDR_WIDTH == REG_ADDR_W) begin : g_dec32
      decoder5_32 u_dec (
         .en     (v_q),
         .addr   (addr_q),
         .onehot (row_en)
      );
   end else begin : g_dec_gen
      // Behavioural decode for non-standard bank sizes.
      always_comb begin
         row_en = '0;
         if (v_q) row_en[addr_q] = 1'b1;
      end
   end

   assign row_data   = data_q;
   assign fwd_data   = data_q;
   assign pend_valid = v_q;
   assign pend_addr  = addr_q;
   assign commit_cnt = cnt_q;

   // Bypass comparators work on the live read addresses, no extra stage.
   assign fwd_a = v_q && (rd_addr_a == addr_q);
   assign fwd_b = v_q && (rd_addr_b == addr_q);

endmodule

// File: tb/tb_regfile_write_decoder.sv
// Self-checking bench for regfile_write_decoder: directed vector table,
// hand-written corner sequences, and a randomized run against a model.
module tb_regfile_write_decoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [63:0] wr_data;
   logic [4:0]  rd_addr_a, rd_addr_b;
   logic [31:0] row_en;
   logic [63:0] row_data, fwd_data;
   logic        pend_valid, fwd_a, fwd_b;
   logic [4:0]  pend_addr;
   logic [15:0] commit_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   regfile_write_decoder #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_addr_a  (rd_addr_a),
      .rd_addr_b  (rd_addr_b),
      .row_en     (row_en),
      .row_data   (row_data),
      .pend_valid (pend_valid),
      .pend_addr  (pend_addr),
      .fwd_a      (fwd_a),
      .fwd_b      (fwd_b),
      .fwd_data   (fwd_data),
      .commit_cnt (commit_cnt)
   );

   // Reference model: the last accepted write and a clamped write count.
   bit          m_v, m_rst;
   int          m_a, m_cnt;
   logic [63:0] m_d;

   always @(posedge clk) begin
      if (reset) begin
         m_v <= 0; m_a <= 0; m_d <= '0; m_cnt <= 0; m_rst <= 1;
      end else begin
         m_rst <= 0;
         m_v   <= wr_en && (wr_addr != 31);
         if (wr_en && (wr_addr != 31)) begin
            m_a   <= int'(wr_addr);
            m_d   <= wr_data;
            m_cnt <= (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string tag);
      logic [31:0] exp_row;
      exp_row = m_v ? (32'd1 << m_a) : 32'd0;
      chk({tag, ".row_en"},     64'(row_en),     64'(exp_row));
      chk({tag, ".pend_valid"}, 64'(pend_valid), 64'(m_v));
      chk({tag, ".fwd_a"},      64'(fwd_a),      64'(m_v && (int'(rd_addr_a) == m_a)));
      chk({tag, ".fwd_b"},      64'(fwd_b),      64'(m_v && (int'(rd_addr_b) == m_a)));
      chk({tag, ".commit_cnt"}, 64'(commit_cnt), 64'(m_cnt));
      if (m_v || m_rst) begin
         chk({tag, ".row_data"},  row_data,        m_d);
         chk({tag, ".fwd_data"},  fwd_data,        m_d);
         chk({tag, ".pend_addr"}, 64'(pend_addr),  64'(m_a));
      end
   endtask

   typedef struct {
      bit          rst, en;
      logic [4:0]  addr, ra, rb;
      logic [63:0] data;
      logic [31:0] e_row;
      bit          e_pv, e_fa, e_fb, e_dchk;
      logic [63:0] e_data;
      logic [15:0] e_cnt;
   } vec_t;

   function automatic vec_t mk(bit rst, bit en, logic [4:0] addr, logic [63:0] data,
                               logic [4:0] ra, logic [4:0] rb, logic [31:0] e_row,
                               bit e_pv, bit e_fa, bit e_fb, bit e_dchk,
                               logic [63:0] e_data, logic [15:0] e_cnt);
      vec_t t;
      t.rst = rst; t.en = en; t.addr = addr; t.data = data; t.ra = ra; t.rb = rb;
      t.e_row = e_row; t.e_pv = e_pv; t.e_fa = e_fa; t.e_fb = e_fb;
      t.e_dchk = e_dchk; t.e_data = e_data; t.e_cnt = e_cnt;
      return t;
   endfunction

   vec_t vecs[$];

   initial begin
      reset = 1; wr_en = 0; wr_addr = 0; wr_data = '0; rd_addr_a = 0; rd_addr_b = 0;

      //               rst en addr data              ra  rb  row          pv fa fb dchk data        cnt
      vecs.push_back(mk(1, 1, 5,  64'h5555,         5,  5,  32'h0,        0, 0, 0, 1, 64'h0,        0));
      vecs.push_back(mk(1, 1, 5,  64'h5555,         5,  5,  32'h0,        0, 0, 0, 1, 64'h0,        0));
      vecs.push_back(mk(0, 0, 5,  64'h5555,         5,  5,  32'h0,        0, 0, 0, 0, 64'h0,        0));
      vecs.push_back(mk(0, 1, 3,  64'hDEAD_BEEF,    0,  3,  32'h0000_0008, 1, 0, 1, 1, 64'hDEAD_BEEF, 1));
      vecs.push_back(mk(0, 0, 3,  64'h0,            3,  3,  32'h0,        0, 0, 0, 0, 64'h0,        1));
      vecs.push_back(mk(0, 1, 31, 64'h77,           31, 31, 32'h0,        0, 0, 0, 0, 64'h0,        1));
      vecs.push_back(mk(0, 1, 7,  64'h1234,         7,  8,  32'h0000_0080, 1, 1, 0, 1, 64'h1234,     2));
      vecs.push_back(mk(0, 1, 7,  64'hAAAA,         7,  7,  32'h0000_0080, 1, 1, 1, 1, 64'hAAAA,     3));
      vecs.push_back(mk(0, 1, 7,  64'hBBBB,         7,  7,  32'h0000_0080, 1, 1, 1, 1, 64'hBBBB,     4));
      vecs.push_back(mk(0, 1, 30, 64'hCCCC,         31, 30, 32'h4000_0000, 1, 0, 1, 1, 64'hCCCC,     5));
      vecs.push_back(mk(0, 0, 7,  64'h0,            7,  7,  32'h0,        0, 0, 0, 0, 64'h0,        5));

      #1;
      foreach (vecs[i]) begin
         reset = vecs[i].rst; wr_en = vecs[i].en; wr_addr = vecs[i].addr;
         wr_data = vecs[i].data; rd_addr_a = vecs[i].ra; rd_addr_b = vecs[i].rb;
         tick();
         chk($sformatf("vec%0d.row_en", i),     64'(row_en),     64'(vecs[i].e_row));
         chk($sformatf("vec%0d.pend_valid", i), 64'(pend_valid), 64'(vecs[i].e_pv));
         chk($sformatf("vec%0d.fwd_a", i),      64'(fwd_a),      64'(vecs[i].e_fa));
         chk($sformatf("vec%0d.fwd_b", i),      64'(fwd_b),      64'(vecs[i].e_fb));
         chk($sformatf("vec%0d.commit_cnt", i), 64'(commit_cnt), 64'(vecs[i].e_cnt));
         if (vecs[i].e_dchk) begin
            chk($sformatf("vec%0d.row_data", i), row_data, vecs[i].e_data);
            chk($sformatf("vec%0d.fwd_data", i), fwd_data, vecs[i].e_data);
         end
      end

      // Forwarding follows a read address change inside the same cycle.
      wr_en = 1; wr_addr = 7; wr_data = 64'h1234; rd_addr_a = 0; rd_addr_b = 0;
      tick();
      wr_en = 0; rd_addr_a = 7; rd_addr_b = 8;
      #1;
      chk("fwd.a_hit",  64'(fwd_a), 64'd1);
      chk("fwd.b_miss", 64'(fwd_b), 64'd0);
      chk("fwd.data",   fwd_data,   64'h1234);
      rd_addr_b = 7;
      #1;
      chk("fwd.b_same_cycle", 64'(fwd_b), 64'd1);
      tick();
      chk("fwd.b_after_idle", 64'(fwd_b), 64'd0);

      // Back-to-back sweep X0..X30 from a clean counter.
      reset = 1; tick(); reset = 0;
      for (int i = 0; i < 31; i++) begin
         wr_en = 1; wr_addr = 5'(i); wr_data = 64'(i);
         tick();
         chk($sformatf("sweep%0d.row_en", i),   64'(row_en), 64'(32'd1 << i));
         chk($sformatf("sweep%0d.row_data", i), row_data,    64'(i));
      end
      wr_en = 0;
      chk("sweep.cnt", 64'(commit_cnt), 64'd31);
      tick();
      chk("sweep.idle_row_en", 64'(row_en), 64'd0);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         reset     = ($urandom_range(0, 49) == 0);
         wr_en     = ($urandom_range(0, 3) != 0);
         wr_addr   = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
         wr_data   = {$urandom, $urandom};
         rd_addr_a = ($urandom_range(0, 1) == 0) ? wr_addr : 5'($urandom_range(0, 31));
         rd_addr_b = 5'($urandom_range(0, 31));
         tick();
         check_model($sformatf("rnd%0d", i));
      end

      // Saturation, then a reset that swallows a write to X9.
      reset = 1; wr_en = 0; tick(); reset = 0;
      for (int i = 0; i < 65540; i++) begin
         wr_en = 1; wr_addr = 5'(i % 31); wr_data = 64'(i);
         tick();
         if (i == 65533) chk("sat.below_max", 64'(commit_cnt), 64'd65534);
      end
      chk("sat.hold", 64'(commit_cnt), 64'hFFFF);
      check_model("sat.model");
      reset = 1; wr_en = 1; wr_addr = 9; wr_data = 64'h9999;
      tick();
      chk("rstmid.row_en", 64'(row_en),     64'd0);
      chk("rstmid.pv",     64'(pend_valid), 64'd0);
      chk("rstmid.cnt",    64'(commit_cnt), 64'd0);
      reset = 0; wr_en = 0;
      tick();
      chk("rstmid.after_row_en", 64'(row_en),     64'd0);
      chk("rstmid.after_cnt",    64'(commit_cnt), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_write_decoder.md
# regfile_write_decoder

Write-side companion to the register-file read multiplexers: it accepts one write request per cycle from the write-back stage, registers it, and drives a one-hot row write enable plus data into the 32-entry register bank one cycle later. It also holds the in-flight write so that read ports in decode can detect and bypass a same-cycle hazard. X31 is the hardwired-zero register, so writes to it are dropped. The block sits between the MEM/WB pipeline register and the register-bank flops.

## Interface
Parameters:
- DATA_WIDTH, 64, register data width
- ADDR_WIDTH, 5, register address width; row count is 2**ADDR_WIDTH

Ports:
- clk  input  1  rising-edge clock, single clock domain
- reset  input  1  synchronous, active-high reset
- wr_en  input  1  write request this cycle
- wr_addr  input  ADDR_WIDTH  destination register
- wr_data  input  DATA_WIDTH  write data
- rd_addr_a  input  ADDR_WIDTH  decode-stage read port A address
- rd_addr_b  input  ADDR_WIDTH  decode-stage read port B address
- row_en  output  2**ADDR_WIDTH  one-hot row write enable to the bank
- row_data  output  DATA_WIDTH  data to all rows, qualified by row_en
- pend_valid  output  1  a committing write is in the stage register
- pend_addr  output  ADDR_WIDTH  address of the committing write
- fwd_a  output  1  port A must take fwd_data instead of the bank
- fwd_b  output  1  port B must take fwd_data instead of the bank
- fwd_data  output  DATA_WIDTH  bypass value, equal to row_data
- commit_cnt  output  16  saturating count of committed non-zero-register writes

## Operation
- Stage register: each cycle it captures {v, addr, data}, where v = wr_en && (wr_addr != 31).
- A write to X31 is discarded at capture. It never asserts row_en and never counts.
- row_en = v ? one-hot(addr) : 0. At most one bit is ever set.
- row_data = fwd_data = captured data. Its value is don't-care when v=0, but it must hold its last value, not X.
- pend_valid = v, and pend_addr = captured addr.
- fwd_a = v && (rd_addr_a == addr) and fwd_b = v && (rd_addr_b == addr). Both are combinational from the stage register and the live read addresses.
  - rd_addr == 31 never forwards, because v is already 0 for that address.
- commit_cnt increments by 1 on every cycle with v=1. It saturates at 16'hFFFF and does not wrap.
- Back-to-back writes to the same register: each write occupies its own cycle, so the last write wins in the bank. Forwarding always reflects the most recent capture.
- Reset asserted mid-operation: on that edge the stage register is cleared. A write presented on the reset cycle is lost.

## Timing
- Latency: a request at edge N drives row_en/row_data during cycle N+1. The bank captures the write at edge N+2's launch, i.e. the bank flops update on the edge ending cycle N+1.
- Throughput: one write per cycle with no stalls. There is no back-pressure and no ready signal.
- Reset values while reset is high:
  - v=0, addr=0, data=0
  - row_en=0, row_data=0, pend_valid=0, pend_addr=0, fwd_a=0, fwd_b=0, fwd_data=0, commit_cnt=0
- Reset takes effect at the first rising edge with reset=1. Outputs stay at reset values until the first edge after reset deasserts.
- fwd_a/fwd_b are valid in the same cycle that rd_addr_a/b change, with no added register stage.

## Structure
- Package regfile_pkg holds the following, shared with the read-port mux tree and the register bank:
  - REG_ADDR_W=5, REG_DATA_W=64, NUM_REGS=32
  - ZERO_REG=5'd31
  - typedef reg_addr_t, typedef reg_data_t
- Sub-module decoder5_32 is purely combinational, with inputs en and addr[4:0] and output one-hot[31:0].
  - It is built from one decoder2_4 enabling four decoder3_8 instances, which is the inverse of the mux8_1/mux4_1 tree used on the read side.
- The top level contains the stage register, the saturating counter, and two ADDR_WIDTH equality comparators.

## Test plan
- Reset: hold reset for 2 cycles with wr_en=1, wr_addr=5 -> all outputs are 0 throughout and at the first cycle after release.
- Single write: wr_en=1, wr_addr=3, wr_data=64'hDEAD_BEEF at edge N -> in cycle N+1, row_en=32'h0000_0008, row_data=64'hDEAD_BEEF and commit_cnt=1; in cycle N+2, row_en=0.
- Zero register: wr_en=1, wr_addr=31, rd_addr_a=31 -> row_en=0, pend_valid=0, fwd_a=0 and commit_cnt unchanged.
- Forwarding: write X7=64'h1234 with rd_addr_a=7, rd_addr_b=8 in the next cycle -> fwd_a=1, fwd_b=0, fwd_data=64'h1234. Changing rd_addr_b to 7 in the same cycle -> fwd_b=1 in that cycle.
- Sweep and back-to-back: write X0..X30 on consecutive cycles with data=addr -> row_en is one-hot and walks bit 0..30, commit_cnt=31, with no gaps between writes.
- Saturation and reset mid-stream: force 65 540 valid writes -> commit_cnt holds at 16'hFFFF. Then assert reset for one cycle during a write to X9 -> row_en stays 0 for X9 and commit_cnt=0.
